state_countdown: RTL and testbench

//  - Consumes the MM:SS BCD value produced by the programming state and counts it down to 00:00 at 1 Hz.
//  - Active only while currentState == stateID.
//  - On reaching zero it raises finished, which the top-level state machine uses to leave the state.
//  - Sits beside the programming state; both feed the shared 4-digit display mux.

---
 rtl/state_countdown.sv | 143 ++++++++++++++
 tb/tb_state_countdown.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/state_countdown.sv
// state_countdown: counts a BCD MM:SS value down to 00:00, one second per tick, while the
// global state machine sits in stateID. Raises finished at 00:00 and holds it until the
// state is left and re-entered.
//
// Optional feature, enabled by defining STATE_COUNTDOWN_BLINK_EN: once finished, each tick
// toggles a blink flag that forces the display output to all-ones (blank on the display).
module state_countdown #(
  parameter logic [2:0] stateID = 3'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  currentState,
  input  logic [15:0] digitsIn,
  input  logic        tick,
  input  logic        pause,
  output logic [15:0] digitsOut,
  output logic        running,
  output logic        finished
);

  logic [15:0] digits_q, digits_d;
  logic        paused_q, paused_d;
  logic        finished_q, finished_d;
  logic [2:0]  prev_state_q, prev_state_d;

  logic        in_state;
  logic        entry;
  logic        at_zero;
  logic [15:0] loaded;
  logic [15:0] decremented;

  // Clamp each digit to its legal range: tens-of-minutes/seconds to 5, units to 9.
  function automatic logic [15:0] clamp_bcd(input logic [15:0] d);
    logic [3:0] m1, m0, s1, s0;
    m1 = (d[15:12] > 4'd5) ? 4'd5 : d[15:12];
    m0 = (d[11:8]  > 4'd9) ? 4'd9 : d[11:8];
    s1 = (d[7:4]   > 4'd5) ? 4'd5 : d[7:4];
    s0 = (d[3:0]   > 4'd9) ? 4'd9 : d[3:0];
    return {m1, m0, s1, s0};
  endfunction

  // Subtract one second in BCD MM:SS; the caller guarantees the value is non-zero.
  function automatic logic [15:0] dec_bcd(input logic [15:0] d);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = d;
    if (s0 != 4'd0) begin
      s0 = s0 - 4'd1;
    end else begin
      s0 = 4'd9;
      if (s1 != 4'd0) begin
        s1 = s1 - 4'd1;
      end else begin
        s1 = 4'd5;
        if (m0 != 4'd0) begin
          m0 = m0 - 4'd1;
        end else begin
          m0 = 4'd9;
          m1 = m1 - 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  assign in_state    = (currentState == stateID);
  assign entry       = in_state && (prev_state_q != stateID);
  assign at_zero     = (digits_q == 16'h0000);
  assign loaded      = clamp_bcd(digitsIn);
  assign decremented = dec_bcd(digits_q);

  // Next-state: entry reload, pause toggle (wins over tick), decrement and zero detection.
  always_comb begin
    digits_d     = digits_q;
    paused_d     = paused_q;
    finished_d   = finished_q;
    prev_state_d = currentState;
    if (entry) begin
      // Ticks and pauses arriving on the entry cycle are dropped.
      digits_d   = loaded;
      paused_d   = 1'b0;
      finished_d = 1'b0;
    end else if (in_state && !finished_q) begin
      if (pause) begin
        paused_d = !paused_q;
      end else if (tick && !paused_q && !at_zero) begin
        digits_d = decremented;
        if (decremented == 16'h0000) begin
          finished_d = 1'b1;
        end
      end
      // Covers a 00:00 load: finished rises on the cycle after entry.
      if (at_zero) begin
        finished_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q     <= 16'h0000;
      paused_q     <= 1'b0;
      finished_q   <= 1'b0;
      prev_state_q <= 3'd0;
    end else begin
      digits_q     <= digits_d;
      paused_q     <= paused_d;
      finished_q   <= finished_d;
      prev_state_q <= prev_state_d;
    end
  end

  assign running  = in_state && !paused_q && !finished_q;
  assign finished = finished_q;

`ifdef STATE_COUNTDOWN_BLINK_EN
  logic blink_q, blink_d;

  // Blink toggles per tick once finished; cleared on entry so a fresh count shows digits.
  always_comb begin
    blink_d = blink_q;
    if (entry) begin
      blink_d = 1'b0;
    end else if (in_state && finished_q && tick) begin
      blink_d = !blink_q;
    end
  end

  // Blink register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign digitsOut = blink_q ? 16'hFFFF : digits_q;
`else
  assign digitsOut = digits_q;
`endif

endmodule

// File: tb/tb_state_countdown.sv
// Directed bench for state_countdown: each step drives one cycle of inputs, pushes the
// expected post-edge outputs to a scoreboard queue, then pops and compares after the edge.
module tb_state_countdown;

  localparam logic [2:0] StCount = 3'd2;
  localparam logic [2:0] StOther = 3'd0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  currentState = 3'd0;
  logic [15:0] digitsIn = 16'h0000;
  logic        tick = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] digitsOut;
  logic        running;
  logic        finished;

  typedef struct {
    string       tag;
    logic [15:0] digits;
    logic        run;
    logic        fin;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  state_countdown #(.stateID(StCount)) dut (
    .clk          (clk),
    .reset        (reset),
    .currentState (currentState),
    .digitsIn     (digitsIn),
    .tick         (tick),
    .pause        (pause),
    .digitsOut    (digitsOut),
    .running      (running),
    .finished     (finished)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, queue the expectation, compare after the edge.
  task automatic step(input string tag, input logic rst, input logic [2:0] st,
                      input logic [15:0] din, input logic tk, input logic ps,
                      input logic [15:0] ed, input logic er, input logic ef);
    exp_t e;
    reset        = rst;
    currentState = st;
    digitsIn     = din;
    tick         = tk;
    pause        = ps;
    sb.push_back('{tag: tag, digits: ed, run: er, fin: ef});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".digits"}, {16'h0, digitsOut}, {16'h0, e.digits});
    check({e.tag, ".running"}, {31'h0, running}, {31'h0, e.run});
    check({e.tag, ".finished"}, {31'h0, finished}, {31'h0, e.fin});
  endtask

  initial begin
    // Reset, then reset overriding a tick while in state.
    step("reset", 1, StOther, 16'h1234, 0, 0, 16'h0000, 0, 0);
    step("reset_ovr", 1, StCount, 16'h1234, 1, 1, 16'h0000, 1, 0);
    step("idle", 0, StOther, 16'h1234, 0, 0, 16'h0000, 0, 0);

    // Load and clamp.
    step("load0130", 0, StCount, 16'h0130, 0, 0, 16'h0130, 1, 0);
    step("hold0130", 0, StCount, 16'h0999, 0, 0, 16'h0130, 1, 0);
    step("exit1", 0, StOther, 16'h0000, 0, 0, 16'h0130, 0, 0);
    step("clamp", 0, StCount, 16'h7A6F, 0, 0, 16'h5959, 1, 0);
    step("exit2", 0, StOther, 16'h0000, 0, 0, 16'h5959, 0, 0);

    // Borrow chain.
    step("load1000", 0, StCount, 16'h1000, 0, 0, 16'h1000, 1, 0);
    step("borrow_m1", 0, StCount, 16'h1000, 1, 0, 16'h0959, 1, 0);
    step("exit3", 0, StOther, 16'h0000, 0, 0, 16'h0959, 0, 0);
    step("load0100", 0, StCount, 16'h0100, 0, 0, 16'h0100, 1, 0);
    step("borrow_m0", 0, StCount, 16'h0100, 1, 0, 16'h0059, 1, 0);
    step("exit4", 0, StOther, 16'h0000, 0, 0, 16'h0059, 0, 0);

    // Count to zero, then a tick after finished.
    step("load0002", 0, StCount, 16'h0002, 0, 0, 16'h0002, 1, 0);
    step("dec0001", 0, StCount, 16'h0002, 1, 0, 16'h0001, 1, 0);
    step("dec0000", 0, StCount, 16'h0002, 1, 0, 16'h0000, 0, 1);
`ifdef STATE_COUNTDOWN_BLINK_EN
    step("blink_on", 0, StCount, 16'h0002, 1, 0, 16'hFFFF, 0, 1);
    step("blink_off", 0, StCount, 16'h0002, 1, 0, 16'h0000, 0, 1);
`else
    step("after_zero", 0, StCount, 16'h0002, 1, 0, 16'h0000, 0, 1);
`endif
    step("exit_fin", 0, StOther, 16'h0000, 0, 0, 16'h0000, 0, 1);

    // Zero load: finished one cycle after entry.
    step("load0000", 0, StCount, 16'h0000, 0, 0, 16'h0000, 1, 0);
    step("zero_fin", 0, StCount, 16'h0000, 0, 0, 16'h0000, 0, 1);
    step("exit5", 0, StOther, 16'h0000, 0, 0, 16'h0000, 0, 1);

    // Pause behaviour; tick on the entry cycle is dropped.
    step("load0010", 0, StCount, 16'h0010, 1, 0, 16'h0010, 1, 0);
    step("dec0009", 0, StCount, 16'h0010, 1, 0, 16'h0009, 1, 0);
    step("pause", 0, StCount, 16'h0010, 0, 1, 16'h0009, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("paused_tick", 0, StCount, 16'h0010, 1, 0, 16'h0009, 0, 0);
    end
    step("resume_tick", 0, StCount, 16'h0010, 1, 1, 16'h0009, 1, 0);
    step("dec0008", 0, StCount, 16'h0010, 1, 0, 16'h0008, 1, 0);
    step("pause_tick", 0, StCount, 16'h0010, 1, 1, 16'h0008, 0, 0);
    step("resume", 0, StCount, 16'h0010, 0, 1, 16'h0008, 1, 0);
    step("dec0007", 0, StCount, 16'h0010, 1, 0, 16'h0007, 1, 0);
    step("dec0006", 0, StCount, 16'h0010, 1, 0, 16'h0006, 1, 0);
    step("dec0005", 0, StCount, 16'h0010, 1, 0, 16'h0005, 1, 0);

    // Exit holds, outside inputs ignored, re-entry reloads.
    step("exit_hold", 0, StOther, 16'h0020, 0, 0, 16'h0005, 0, 0);
    step("out_tick", 0, StOther, 16'h0020, 1, 0, 16'h0005, 0, 0);
    step("out_pause", 0, StOther, 16'h0020, 0, 1, 16'h0005, 0, 0);
    step("reenter", 0, StCount, 16'h0020, 0, 0, 16'h0020, 1, 0);
    step("dec0019", 0, StCount, 16'h0020, 1, 0, 16'h0019, 1, 0);
    step("exit6", 0, StOther, 16'h0000, 0, 0, 16'h0019, 0, 0);

    // Reset mid-count, then reload because prevState was cleared.
    step("load0437", 0, StCount, 16'h0437, 0, 0, 16'h0437, 1, 0);
    step("mid_reset", 1, StCount, 16'h0437, 1, 0, 16'h0000, 1, 0);
    step("post_reset", 0, StCount, 16'h0437, 1, 0, 16'h0437, 1, 0);
    step("dec0436", 0, StCount, 16'h0437, 1, 0, 16'h0436, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
